multiply_seq_fixed: RTL

//  Sequential signed fixed-point multiplier; inverse companion of the divider in the ray-tracer math path.
//  One shift-add iteration per clock, sign-magnitude datapath, round-half-away-from-zero, optional saturation.

---
 rtl/multiply_seq_fixed_if.sv | 33 +++
 rtl/multiply_seq_fixed.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multiply_seq_fixed_if.sv
// Operand/result bundle for the sequential fixed-point multiplier.
// master = upstream producer of operands, slave = the multiplier itself.
interface multiply_seq_fixed_if #(
  parameter int D_WIDTH = 32
);
  logic [D_WIDTH-1:0] multiplicand;
  logic [D_WIDTH-1:0] multiplier;
  logic               valid_in;
  logic               ready_out;
  logic [D_WIDTH-1:0] product;
  logic               overflow;
  logic               valid_out;

  modport master (
    output multiplicand,
    output multiplier,
    output valid_in,
    input  ready_out,
    input  product,
    input  overflow,
    input  valid_out
  );

  modport slave (
    input  multiplicand,
    input  multiplier,
    input  valid_in,
    output ready_out,
    output product,
    output overflow,
    output valid_out
  );
endinterface

// File: rtl/multiply_seq_fixed.sv
// Sequential signed fixed-point multiplier (Q(D_WIDTH-Q_BITS).Q_BITS).
// One shift-add step per clock on operand magnitudes, then a single
// round-half-away-from-zero step and sign restoration.
// Optional build macro MULT_SATURATE_EN: clamp the product on overflow
// instead of returning the wrapped low D_WIDTH bits.
module multiply_seq_fixed #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  multiply_seq_fixed_if.slave  bus
);

  localparam int CNT_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam int ACC_W = 2 * D_WIDTH;
  localparam int MAG_W = ACC_W - Q_BITS + 1;

  // Rounding constant: half an LSB of the output format.
  localparam logic [ACC_W:0]   HALF_LSB  = (ACC_W + 1)'(1) << (Q_BITS - 1);
  // Largest representable negative magnitude, 2^(D-1).
  localparam logic [MAG_W-1:0] NEG_LIMIT = MAG_W'(1) << (D_WIDTH - 1);
  localparam logic [MAG_W-1:0] POS_LIMIT = NEG_LIMIT - MAG_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [D_WIDTH-1:0] mcand_reg;   // |A|, consumed LSB-first
  logic [ACC_W-1:0]   mplier_reg;  // |B| << cnt, kept pre-shifted
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_reg;

  logic [D_WIDTH-1:0] product_reg;
  logic               overflow_reg;
  logic               valid_out_reg;

  // Operand magnitudes; -2^(D-1) maps onto 2^(D-1), which still fits unsigned.
  logic [D_WIDTH-1:0] a_raw;
  logic [D_WIDTH-1:0] b_raw;
  logic [D_WIDTH-1:0] abs_a;
  logic [D_WIDTH-1:0] abs_b;

  assign a_raw = bus.multiplicand;
  assign b_raw = bus.multiplier;
  assign abs_a = a_raw[D_WIDTH-1] ? (~a_raw) + D_WIDTH'(1) : a_raw;
  assign abs_b = b_raw[D_WIDTH-1] ? (~b_raw) + D_WIDTH'(1) : b_raw;

  logic last_iter;
  assign last_iter = (cnt_reg == CNT_W'(D_WIDTH - 1));

  // Rounding and range check on the full-precision magnitude.
  logic [ACC_W:0]     rnd_sum;
  logic [MAG_W-1:0]   mag;
  logic               mag_ovf;
  logic [D_WIDTH-1:0] mag_low;
  logic [D_WIDTH-1:0] wrapped;
  logic [D_WIDTH-1:0] result;

  assign rnd_sum = {1'b0, acc_reg} + HALF_LSB;
  assign mag     = rnd_sum[ACC_W:Q_BITS];
  assign mag_ovf = sign_reg ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
  assign mag_low = mag[D_WIDTH-1:0];
  // Negating a zero magnitude yields zero, so no negative zero can appear.
  assign wrapped = sign_reg ? (~mag_low) + D_WIDTH'(1) : mag_low;

`ifdef MULT_SATURATE_EN
  logic [D_WIDTH-1:0] sat_value;
  assign sat_value = sign_reg ? {1'b1, {(D_WIDTH-1){1'b0}}}
                              : {1'b0, {(D_WIDTH-1){1'b1}}};
  assign result    = mag_ovf ? sat_value : wrapped;
`else
  assign result    = wrapped;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, D_WIDTH iterations, one rounding cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.valid_in) state_next = RUN;
      RUN:     if (last_iter)    state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: operands are taken only while idle.
  always_comb begin
    bus.ready_out = (state_reg == IDLE);
  end

  // Shift-add datapath: latch magnitudes on accept, one partial product per RUN cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sign_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.valid_in) begin
            mcand_reg  <= abs_a;
            mplier_reg <= {{D_WIDTH{1'b0}}, abs_b};
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= a_raw[D_WIDTH-1] ^ b_raw[D_WIDTH-1];
          end
        end
        RUN: begin
          if (mcand_reg[0]) begin
            acc_reg <= acc_reg + mplier_reg;
          end
          mcand_reg  <= mcand_reg >> 1;
          mplier_reg <= mplier_reg << 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated only in FINISH, held otherwise; valid_out is a one-cycle pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      product_reg   <= '0;
      overflow_reg  <= 1'b0;
      valid_out_reg <= 1'b0;
    end else begin
      valid_out_reg <= (state_reg == FINISH);
      if (state_reg == FINISH) begin
        product_reg  <= result;
        overflow_reg <= mag_ovf;
      end
    end
  end

  assign bus.product   = product_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.valid_out = valid_out_reg;

endmodule
